// File: rtl/axi2per_outstanding_tracker_if.sv
// Handshake bundle between the bridge FSMs and the outstanding tracker.
// Sync pulses flow in from the bridge; counts, stalls, busy and errors flow back.
interface axi2per_outstanding_tracker_if #(
  parameter int CNT_W = 4
);
  logic             aw_sync_i;
  logic             b_sync_i;
  logic             ar_sync_i;
  logic             r_sync_i;
  logic             clr_err_i;
  logic [CNT_W-1:0] aw_count_o;
  logic [CNT_W-1:0] ar_count_o;
  logic             aw_stall_o;
  logic             ar_stall_o;
  logic             busy_o;
  logic [3:0]       err_o;

  modport master (
    output aw_sync_i, b_sync_i, ar_sync_i, r_sync_i, clr_err_i,
    input  aw_count_o, ar_count_o, aw_stall_o, ar_stall_o, busy_o, err_o
  );

  modport slave (
    input  aw_sync_i, b_sync_i, ar_sync_i, r_sync_i, clr_err_i,
    output aw_count_o, ar_count_o, aw_stall_o, ar_stall_o, busy_o, err_o
  );
endinterface

// File: rtl/axi2per_outstanding_tracker.sv
// Outstanding AW/AR tracker: saturating per-channel counters, request throttle,
// sticky under/overflow flags and a glitch-free busy with a programmable idle tail.
module axi2per_outstanding_tracker #(
  parameter int CNT_W       = 4,
  parameter int MAX_AW      = 8,
  parameter int MAX_AR      = 8,
  parameter int IDLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  axi2per_outstanding_tracker_if.slave bus
);

  localparam int TMR_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] AW_LIM  = CNT_W'(MAX_AW);
  localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(MAX_AR);
  localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(IDLE_CYCLES);

  if (MAX_AW < 1 || MAX_AW > (2**CNT_W) - 1) begin : g_bad_max_aw
    $error("MAX_AW out of range 1..2^CNT_W-1");
  end
  if (MAX_AR < 1 || MAX_AR > (2**CNT_W) - 1) begin : g_bad_max_ar
    $error("MAX_AR out of range 1..2^CNT_W-1");
  end

  // Channel 0 is write (AW/B), channel 1 is read (AR/R).
  logic [1:0]            inc, dec, ovf, udf;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [3:0]            err_q, err_d;
  logic                  tmr_load;

  assign inc = {bus.ar_sync_i, bus.aw_sync_i};
  assign dec = {bus.r_sync_i,  bus.b_sync_i};

  always_comb begin
    cnt_d = cnt_q;
    ovf   = '0;
    udf   = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (inc[ch] && !dec[ch]) begin
        if (cnt_q[ch] == CNT_SAT) ovf[ch]   = 1'b1;
        else                      cnt_d[ch] = cnt_q[ch] + 1'b1;
      end else if (dec[ch] && !inc[ch]) begin
        if (cnt_q[ch] == '0) udf[ch]   = 1'b1;
        else                 cnt_d[ch] = cnt_q[ch] - 1'b1;
      end
    end
  end

  // A fresh error wins over clear only for its own bit.
  assign err_d = (bus.clr_err_i ? 4'b0000 : err_q) | {udf[1], ovf[1], udf[0], ovf[0]};

  assign tmr_load = (cnt_q[0] != '0) || (cnt_q[1] != '0) || bus.aw_sync_i || bus.ar_sync_i;

  always_comb begin
    tmr_d = tmr_q;
    if (tmr_load)          tmr_d = TMR_LD;
    else if (tmr_q != '0)  tmr_d = tmr_q - 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmr_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign bus.aw_count_o = cnt_q[0];
  assign bus.ar_count_o = cnt_q[1];
  assign bus.aw_stall_o = (cnt_q[0] >= AW_LIM);
  assign bus.ar_stall_o = (cnt_q[1] >= AR_LIM);
  assign bus.busy_o     = (cnt_q[0] != '0) || (cnt_q[1] != '0) || (tmr_q != '0);
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_axi2per_outstanding_tracker.sv
// Scoreboard bench: three tracker configurations share one stimulus stream; a
// behavioural model pushes expected outputs per cycle, popped after each edge.
module tb_axi2per_outstanding_tracker;

  typedef struct {
    int aw;
    int ar;
    int aws;
    int ars;
    int busy;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // d0: defaults; d1: narrow counters, tight limits, no tail; d2: longer tail.
  axi2per_outstanding_tracker_if #(.CNT_W(4)) if0 ();
  axi2per_outstanding_tracker_if #(.CNT_W(2)) if1 ();
  axi2per_outstanding_tracker_if #(.CNT_W(4)) if2 ();

  axi2per_outstanding_tracker #(.CNT_W(4), .MAX_AW(8), .MAX_AR(8), .IDLE_CYCLES(2))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  axi2per_outstanding_tracker #(.CNT_W(2), .MAX_AW(3), .MAX_AR(2), .IDLE_CYCLES(0))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  axi2per_outstanding_tracker #(.CNT_W(4), .MAX_AW(8), .MAX_AR(8), .IDLE_CYCLES(3))
    dut2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));

  int cfg_sat  [3] = '{15, 3, 15};
  int cfg_maw  [3] = '{8, 3, 8};
  int cfg_mar  [3] = '{8, 2, 8};
  int cfg_idle [3] = '{2, 0, 3};

  int       m_aw  [3];
  int       m_ar  [3];
  int       m_tmr [3];
  bit [3:0] m_err [3];
  exp_t     sb    [3][$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t observe(input int d);
    exp_t o;
    case (d)
      0: begin
        o.aw = int'(if0.aw_count_o); o.ar = int'(if0.ar_count_o);
        o.aws = int'(if0.aw_stall_o); o.ars = int'(if0.ar_stall_o);
        o.busy = int'(if0.busy_o); o.err = int'(if0.err_o);
      end
      1: begin
        o.aw = int'(if1.aw_count_o); o.ar = int'(if1.ar_count_o);
        o.aws = int'(if1.aw_stall_o); o.ars = int'(if1.ar_stall_o);
        o.busy = int'(if1.busy_o); o.err = int'(if1.err_o);
      end
      default: begin
        o.aw = int'(if2.aw_count_o); o.ar = int'(if2.ar_count_o);
        o.aws = int'(if2.aw_stall_o); o.ars = int'(if2.ar_stall_o);
        o.busy = int'(if2.busy_o); o.err = int'(if2.err_o);
      end
    endcase
    return o;
  endfunction

  // Reference behaviour for one clock edge of configuration d.
  task automatic model_edge(input int d, input bit aw, b, ar, r, clr, rs);
    bit [3:0] nerr = 4'b0000;
    bool_t_dummy: begin end
    if (rs) begin
      m_aw[d] = 0; m_ar[d] = 0; m_tmr[d] = 0; m_err[d] = 4'b0000;
    end else begin
      bit load = (m_aw[d] > 0) || (m_ar[d] > 0) || aw || ar;
      if (aw && !b) begin
        if (m_aw[d] == cfg_sat[d]) nerr[0] = 1'b1; else m_aw[d]++;
      end else if (b && !aw) begin
        if (m_aw[d] == 0) nerr[1] = 1'b1; else m_aw[d]--;
      end
      if (ar && !r) begin
        if (m_ar[d] == cfg_sat[d]) nerr[2] = 1'b1; else m_ar[d]++;
      end else if (r && !ar) begin
        if (m_ar[d] == 0) nerr[3] = 1'b1; else m_ar[d]--;
      end
      m_err[d] = (clr ? 4'b0000 : m_err[d]) | nerr;
      if (load)              m_tmr[d] = cfg_idle[d];
      else if (m_tmr[d] > 0) m_tmr[d]--;
    end
  endtask

  task automatic step(input bit aw, b, ar, r, clr, rs);
    @(negedge clk);
    rst = rs;
    if0.aw_sync_i = aw; if0.b_sync_i = b; if0.ar_sync_i = ar; if0.r_sync_i = r; if0.clr_err_i = clr;
    if1.aw_sync_i = aw; if1.b_sync_i = b; if1.ar_sync_i = ar; if1.r_sync_i = r; if1.clr_err_i = clr;
    if2.aw_sync_i = aw; if2.b_sync_i = b; if2.ar_sync_i = ar; if2.r_sync_i = r; if2.clr_err_i = clr;
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      model_edge(d, aw, b, ar, r, clr, rs);
      e.aw   = m_aw[d];
      e.ar   = m_ar[d];
      e.aws  = (m_aw[d] >= cfg_maw[d]) ? 1 : 0;
      e.ars  = (m_ar[d] >= cfg_mar[d]) ? 1 : 0;
      e.busy = (m_aw[d] > 0 || m_ar[d] > 0 || m_tmr[d] > 0) ? 1 : 0;
      e.err  = int'(m_err[d]);
      sb[d].push_back(e);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      exp_t g;
      if (sb[d].size() == 0) begin
        check($sformatf("d%0d sb_empty", d), 0, 1);
      end else begin
        e = sb[d].pop_front();
        g = observe(d);
        check($sformatf("d%0d aw_count", d), g.aw,   e.aw);
        check($sformatf("d%0d ar_count", d), g.ar,   e.ar);
        check($sformatf("d%0d aw_stall", d), g.aws,  e.aws);
        check($sformatf("d%0d ar_stall", d), g.ars,  e.ars);
        check($sformatf("d%0d busy",     d), g.busy, e.busy);
        check($sformatf("d%0d err",      d), g.err,  e.err);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    // Three writes then three responses, tail observed to the end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    idle(4);
    // Read throttle: two reads stall d1, one response releases it
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    idle(4);
    // Write saturation on d1, then clear, then drain into underflow
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // Underflow at zero, then simultaneous inc+dec at zero and at saturation
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Clear and a new error in the same cycle
    step(1, 0, 0, 1, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(5);
    // Tail reload: new read during the idle tail
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(5);
    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi2per_outstanding_tracker.md
Name: axi2per_outstanding_tracker

Overview:
Parametrised outstanding-transaction tracker for the AXI-to-peripheral bridge. It counts accepted AW/AR requests against completed B/R responses and exposes per-channel counts. It throttles new requests at a configurable limit, flags counter errors, and holds busy_o for a programmable idle tail so clock gating and power control never see glitches between back-to-back transactions. It sits beside the bridge request/response FSMs and feeds the cluster busy/clock-gate logic.

Parameters:
CNT_W, 4, width of each outstanding counter; saturation value is 2^CNT_W-1.
MAX_AW, 8, write outstanding limit; legal range 1..2^CNT_W-1.
MAX_AR, 8, read outstanding limit; legal range 1..2^CNT_W-1.
IDLE_CYCLES, 2, cycles busy_o stays high after both counts reach zero; 0 disables the tail. Timer width is clog2(IDLE_CYCLES+1), minimum 1.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
aw_sync_i  in  1  single-cycle pulse, write request accepted
b_sync_i  in  1  single-cycle pulse, write response delivered
ar_sync_i  in  1  single-cycle pulse, read request accepted
r_sync_i  in  1  single-cycle pulse, read response delivered (last beat)
clr_err_i  in  1  clears sticky error flags
aw_count_o  out  CNT_W  current write outstanding count
ar_count_o  out  CNT_W  current read outstanding count
aw_stall_o  out  1  aw_count_o >= MAX_AW; bridge must not accept AW
ar_stall_o  out  1  ar_count_o >= MAX_AR; bridge must not accept AR
busy_o  out  1  any transaction outstanding or idle tail running
err_o  out  4  sticky {ar_underflow, ar_overflow, aw_underflow, aw_overflow}

Behaviour:
- Reset (rst_i=1 at a posedge): counts=0, idle timer=0, err_o=0. Outputs then read aw/ar_count_o=0, stalls=0, busy_o=0. Reset mid-operation discards all in-flight state; no error is flagged.
- AW and AR channels are independent and identical. Per channel, on each posedge:
  - inc only -> count+1
  - dec only -> count-1
  - both or neither -> hold
- Count outputs are registered. Latency from a sync pulse to the count output is 1 cycle.
- Inc only with count=2^CNT_W-1 -> hold (no wrap); set the overflow bit.
- Dec only with count=0 -> hold (no wrap); set the underflow bit.
- Simultaneous inc+dec never flags, even at 0 or at saturation.
- Stall outputs are combinational from the registered counts only, with no path from sync inputs. An AW pulse while aw_stall_o=1 is still counted (up to saturation); it is a protocol violation, not suppressed here.
- Idle timer, per posedge:
  - if aw_count!=0, ar_count!=0, aw_sync_i or ar_sync_i -> load IDLE_CYCLES
  - else if timer!=0 -> decrement
- busy_o = (aw_count!=0) | (ar_count!=0) | (timer!=0), combinational from registers.
  - busy_o rises 1 cycle after the first sync pulse.
  - busy_o falls exactly IDLE_CYCLES cycles after both counts become 0.
  - With IDLE_CYCLES=0, busy_o equals count-nonzero, i.e. legacy busy-unit behaviour.
  - A new request during the tail keeps busy_o high continuously and reloads the timer.
- err_o bits set 1 cycle after the offending event and stay set until clr_err_i. If clr_err_i and a new error occur in the same cycle, set wins for that bit and the other bits clear.
- Elaboration check: error if MAX_AW or MAX_AR is 0 or exceeds 2^CNT_W-1.

Test Plan:
1. Reset, 3 aw_sync pulses at cycles 1-3, then 3 b_sync pulses at cycles 6-8 (IDLE_CYCLES=2) -> aw_count_o 1,2,3 at cycles 2-4; returns to 0 at cycle 9; busy_o high cycles 2-10, low at 11; err_o=0.
2. MAX_AR=2: ar_sync at cycles 1 and 2 -> ar_stall_o=1 from cycle 3. One r_sync at cycle 5 -> ar_count_o=1 and ar_stall_o=0 at cycle 6.
3. CNT_W=2, MAX_AW=3, 4 consecutive aw_sync -> aw_count_o saturates at 3; err_o[0]=1 from cycle 5. clr_err_i at cycle 7 -> err_o=0 at cycle 8.
4. b_sync with aw_count=0 -> count stays 0, err_o[1]=1. Simultaneous aw_sync+b_sync at count 0 -> count 0, no new error.
5. IDLE_CYCLES=3: last r_sync drops count to 0; new ar_sync issued 2 cycles later -> busy_o never deasserts. Repeat with IDLE_CYCLES=0 -> busy_o drops the same cycle the count reads 0.
6. rst_i asserted with aw_count=5 and ar_count=2 -> next cycle all counts 0, busy_o=0, stalls 0, err_o=0.
